// File: rtl/ifu_fetch_req_queue.sv
// Fetch-request queue between the PC generator / branch predictor and the ICache.
// Takes up to two in-order requests per cycle (lane 0 older) and presents the
// oldest entry show-ahead to the ICache with a valid/ready handshake.
// Lane 1 is dropped when lane 0 is predicted taken (wrong path) or when lane 0
// is not valid. Flush beats stall; reset beats both.
module ifu_fetch_req_queue #(
    parameter int DEPTH        = 16,
    parameter int PC_W         = 32,
    parameter int CUT_W        = 2,
    parameter int AFULL_THRESH = DEPTH - 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [1:0]             enq_valid,
    input  logic [2*PC_W-1:0]      enq_pc,
    input  logic [2*CUT_W-1:0]     enq_cut_pos,
    input  logic [1:0]             enq_pred_taken,
    input  logic [2*PC_W-1:0]      enq_pred_target,
    output logic                   enq_ready,
    output logic                   deq_valid,
    output logic [PC_W-1:0]        deq_pc,
    output logic [CUT_W-1:0]       deq_cut_pos,
    output logic                   deq_pred_taken,
    output logic [PC_W-1:0]        deq_pred_target,
    input  logic                   icache_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // enq_ready needs room for both lanes, so the highest count that still
    // accepts is DEPTH-2.
    localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - 2);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(AFULL_THRESH);

    logic [PC_W-1:0]  pc_mem     [DEPTH];
    logic [CUT_W-1:0] cut_mem    [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [PC_W-1:0]  target_mem [DEPTH];

    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [PTR_W-1:0] tail_ptr_p1;
    logic             wr_lane0;
    logic             wr_lane1;
    logic             deq_fire;
    logic [CNT_W-1:0] n_enq;

    assign enq_ready   = !stall && (count <= ENQ_LIMIT);
    assign wr_lane0    = enq_valid[0] && enq_ready;
    assign wr_lane1    = wr_lane0 && enq_valid[1] && !enq_pred_taken[0];
    assign n_enq       = CNT_W'(wr_lane0) + CNT_W'(wr_lane1);
    assign tail_ptr_p1 = tail_ptr + PTR_W'(1);

    assign deq_valid       = (count != '0);
    assign deq_fire        = deq_valid && icache_ready && !stall;
    assign deq_pc          = pc_mem[head_ptr];
    assign deq_cut_pos     = cut_mem[head_ptr];
    assign deq_pred_taken  = taken_mem[head_ptr];
    assign deq_pred_target = target_mem[head_ptr];

    assign almost_full = (count >= AFULL_LVL);

    // Entry storage: cleared on reset, lane writes land at tail and tail+1 (wrapping).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]     <= '0;
                cut_mem[i]    <= '0;
                taken_mem[i]  <= 1'b0;
                target_mem[i] <= '0;
            end
        end else if (!flush) begin
            if (wr_lane0) begin
                pc_mem[tail_ptr]     <= enq_pc[PC_W-1:0];
                cut_mem[tail_ptr]    <= enq_cut_pos[CUT_W-1:0];
                taken_mem[tail_ptr]  <= enq_pred_taken[0];
                target_mem[tail_ptr] <= enq_pred_target[PC_W-1:0];
            end
            if (wr_lane1) begin
                pc_mem[tail_ptr_p1]     <= enq_pc[2*PC_W-1:PC_W];
                cut_mem[tail_ptr_p1]    <= enq_cut_pos[2*CUT_W-1:CUT_W];
                taken_mem[tail_ptr_p1]  <= enq_pred_taken[1];
                target_mem[tail_ptr_p1] <= enq_pred_target[2*PC_W-1:PC_W];
            end
        end
    end

    // Pointer and occupancy update; stall is already folded into wr_lane*/deq_fire.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (deq_fire) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            tail_ptr <= tail_ptr + PTR_W'(n_enq);
            count    <= count + n_enq - CNT_W'(deq_fire);
        end
    end

endmodule
